// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and frame-length helper for uart_tx and uart_rx.
// The PARITY state and parity bit exist only when UART_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_t;

  // Clock cycles from the start-bit edge to the end of the last stop bit.
  function automatic int frame_cycles(input int shift, input int word_width, input int stop_bits);
    return (1 + word_width + PARITY_BITS + stop_bits) << shift;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high in the last cycle of every 2^SHIFT-cycle bit period.
// clear holds the count at zero so the first period starts cleanly after it drops.
module uart_baud_tick #(
  parameter int SHIFT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (SHIFT > 0) ? SHIFT : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << SHIFT) - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_MAX) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WORD_WIDTH data bits LSB first, optional even parity
// (macro UART_TX_PARITY_EN), STOP_BITS stop bits; every bit lasts 2^SHIFT clk cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int SHIFT      = 1,
  parameter int WORD_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  tx_start,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_done
);

  localparam int BCW = ($clog2(WORD_WIDTH) > 0) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_WIDTH - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t           state_reg;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [BCW-1:0]        bit_cnt_reg;
  logic                  stop_cnt_reg;
  logic                  tx_reg;
  logic                  tx_ready_reg;
  logic                  tx_done_reg;
  logic                  tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg;
`endif

  // The timer is held cleared while idle so a frame's first bit period starts at acceptance.
  uart_baud_tick #(
    .SHIFT (SHIFT)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tx_ready_reg),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= 1'b1;
      tx_ready_reg <= 1'b1;
      tx_done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tx_start && tx_ready_reg) begin
            shift_reg    <= din;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= ^din;
`endif
            tx_reg       <= 1'b0;
            tx_ready_reg <= 1'b0;
            state_reg    <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_reg      <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= '0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_reg       <= parity_reg;
              state_reg    <= PARITY;
`else
              tx_reg       <= 1'b1;
              stop_cnt_reg <= 1'b0;
              state_reg    <= STOP;
`endif
            end else begin
              tx_reg      <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx_reg       <= 1'b1;
            stop_cnt_reg <= 1'b0;
            state_reg    <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_cnt_reg == LAST_STOP) begin
              tx_ready_reg <= 1'b1;
              tx_done_reg  <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          tx_reg       <= 1'b1;
          tx_ready_reg <= 1'b1;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_reg;
  assign tx_ready = tx_ready_reg;
  assign tx_done  = tx_done_reg;

endmodule
